// File: rtl/branch_predictor_btb_if.sv
// branch_predictor_btb_if: IF lookup, ID resolve and statistics signals between the pipeline and the BTB.
interface branch_predictor_btb_if #(
  parameter int XLEN   = 32,
  parameter int STAT_W = 16
);
  logic              stall_i;
  logic              flush_i;
  logic [XLEN-1:0]   pc_i;
  logic              pred_taken_o;
  logic [XLEN-1:0]   pred_target_o;
  logic              upd_valid_i;
  logic [XLEN-1:0]   upd_pc_i;
  logic              upd_taken_i;
  logic [XLEN-1:0]   upd_target_i;
  logic              mispredict_o;
  logic [XLEN-1:0]   redirect_pc_o;
  logic [STAT_W-1:0] stat_branches_o;
  logic [STAT_W-1:0] stat_mispred_o;
  modport master (
    output pc_i, stall_i, flush_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
    input  pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o, stat_branches_o, stat_mispred_o
  );
  modport slave (
    input  pc_i, stall_i, flush_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
    output pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o, stat_branches_o, stat_mispred_o
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: direct-mapped BTB with saturating direction counters, IF->ID prediction shadow,
// resolve-time redirect and saturating branch/mispredict statistics.
module branch_predictor_btb #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input logic                 clk_i,
  input logic                 start_i,
  branch_predictor_btb_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CNT_W-1:0]  CTR_MAX  = '1;
  localparam logic [CNT_W-1:0]  CTR_WT   = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0]  CTR_WNT  = CTR_WT - CNT_W'(1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [ENTRIES-1:0]            r_valid;
  logic [ENTRIES-1:0][TAG_W-1:0] r_tag;
  logic [ENTRIES-1:0][XLEN-1:0]  r_target;
  logic [ENTRIES-1:0][CNT_W-1:0] r_ctr;
  logic                          r_sh_taken;
  logic [XLEN-1:0]               r_sh_target;
  logic [STAT_W-1:0]             r_branches;
  logic [STAT_W-1:0]             r_mispred;
  logic [IDX_W-1:0]              w_idx;
  logic [IDX_W-1:0]              w_uidx;
  logic [TAG_W-1:0]              w_tag;
  logic [TAG_W-1:0]              w_utag;
  logic                          w_hit;
  logic                          w_uhit;
  logic                          w_pred;
  logic [XLEN-1:0]               w_target;
  logic                          w_mp;
  logic                          w_unused;

  assign w_idx    = bus.pc_i[IDX_W+1:2];
  assign w_tag    = bus.pc_i[XLEN-1:IDX_W+2];
  assign w_uidx   = bus.upd_pc_i[IDX_W+1:2];
  assign w_utag   = bus.upd_pc_i[XLEN-1:IDX_W+2];
  assign w_unused = ^bus.pc_i[1:0];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_uhit   = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_pred   = w_hit && r_ctr[w_idx][CNT_W-1];
  assign w_target = w_pred ? r_target[w_idx] : '0;
  // A taken branch is only correct if the shadowed target matches too.
  assign w_mp = bus.upd_valid_i && ((r_sh_taken != bus.upd_taken_i) ||
                (bus.upd_taken_i && (r_sh_target != bus.upd_target_i)));

  assign bus.pred_taken_o    = w_pred;
  assign bus.pred_target_o   = w_target;
  assign bus.mispredict_o    = w_mp;
  assign bus.redirect_pc_o   = bus.upd_taken_i ? bus.upd_target_i : bus.upd_pc_i + XLEN'(4);
  assign bus.stat_branches_o = r_branches;
  assign bus.stat_mispred_o  = r_mispred;

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      r_sh_taken  <= 1'b0;
      r_sh_target <= '0;
    end else if (w_mp || bus.flush_i) begin
      r_sh_taken  <= 1'b0;
      r_sh_target <= '0;
    end else if (!bus.stall_i) begin
      r_sh_taken  <= w_pred;
      r_sh_target <= w_target;
    end
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      r_valid  <= '0;
      r_tag    <= '0;
      r_target <= '0;
      r_ctr    <= {ENTRIES{CTR_WNT}};
    end else if (bus.upd_valid_i) begin
      if (w_uhit) begin
        if (bus.upd_taken_i) begin
          r_ctr[w_uidx]    <= (r_ctr[w_uidx] == CTR_MAX) ? CTR_MAX : r_ctr[w_uidx] + CNT_W'(1);
          r_target[w_uidx] <= bus.upd_target_i;
        end else begin
          r_ctr[w_uidx] <= (r_ctr[w_uidx] == '0) ? '0 : r_ctr[w_uidx] - CNT_W'(1);
        end
      end else if (bus.upd_taken_i) begin
        r_valid[w_uidx]  <= 1'b1;
        r_tag[w_uidx]    <= w_utag;
        r_target[w_uidx] <= bus.upd_target_i;
        r_ctr[w_uidx]    <= CTR_WT;
      end
    end
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      r_branches <= '0;
      r_mispred  <= '0;
    end else if (bus.upd_valid_i) begin
      if (r_branches != STAT_MAX) r_branches <= r_branches + STAT_W'(1);
      if (w_mp && (r_mispred != STAT_MAX)) r_mispred <= r_mispred + STAT_W'(1);
    end
  end
endmodule

// File: doc/branch_predictor_btb.md
# branch_predictor_btb

Parametrised branch target buffer with per-entry saturating direction counters for the 5-stage pipelined RISC-V core. It replaces the fixed predict-not-taken behaviour: branches still resolve in ID and flush IF. The block predicts taken branches in IF from the current PC and carries that prediction into ID. When the branch resolves it compares the prediction with the outcome, drives the redirect and flush request, trains the table, and keeps saturating branch/mispredict statistics.

## Interface
Parameters:
- XLEN, 32: address/target width.
- ENTRIES, 16: table depth; power of two, ≥2. IDX_W = log2(ENTRIES).
- CNT_W, 2: direction counter width, ≥1.
- STAT_W, 16: statistics counter width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- start_i  in  1  reset, asynchronous, active-low (low = reset).
- pc_i  in  XLEN  IF-stage PC for lookup.
- stall_i  in  1  IF/ID hold (load-use stall); ID shadow keeps its value.
- flush_i  in  1  external IF flush; ID shadow loads a bubble.
- pred_taken_o  out  1  IF prediction: taken.
- pred_target_o  out  XLEN  IF predicted target (0 when not taken).
- upd_valid_i  in  1  branch in ID resolved this cycle.
- upd_pc_i  in  XLEN  PC of the resolving branch.
- upd_taken_i  in  1  actual direction.
- upd_target_i  in  XLEN  actual taken target.
- mispredict_o  out  1  redirect request; also the IF flush.
- redirect_pc_o  out  XLEN  correct next PC.
- stat_branches_o  out  STAT_W  resolved-branch count.
- stat_mispred_o  out  STAT_W  mispredict count.

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[XLEN-1:IDX_W+2]. Each entry holds valid, tag, target, and ctr[CNT_W].
- Lookup is combinational. Hit = valid && tag match. pred_taken_o = hit && ctr MSB. pred_target_o = pred_taken_o ? target : 0.
- ID shadow registers hold pred_taken and pred_target:
  - if mispredict_o or flush_i: load 0.
  - else if !stall_i: load the lookup outputs.
  - else: hold.
- mispredict_o = upd_valid_i && (shadow_taken != upd_taken_i || (upd_taken_i && shadow_target != upd_target_i)).
- redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + 4. It is valid only while mispredict_o = 1; otherwise it is don't-care but still driven.
- Training occurs on upd_valid_i and uses upd_pc_i's index and tag:
  - Hit, taken: ctr saturating increment (max 2^CNT_W−1); target ← upd_target_i.
  - Hit, not taken: ctr saturating decrement (min 0); target unchanged.
  - Miss, taken: allocate/overwrite the indexed entry with valid=1, new tag, target, ctr = 2^(CNT_W−1) (weakly taken).
  - Miss, not taken: no change.
- Statistics: on upd_valid_i, stat_branches += 1. On mispredict_o, stat_mispred += 1. Both saturate at 2^STAT_W−1 and never wrap.

## Timing
- Reset (start_i low, asynchronous, takes effect immediately, including mid-operation):
  - all valid = 0, ctr = 2^(CNT_W−1)−1 (weakly not-taken), targets = 0;
  - shadow = 0; stats = 0.
  - Consequences: pred_taken_o = 0, pred_target_o = 0, mispredict_o = 0.
- Reset release is synchronous to the next rising edge; the first edge after start_i rises performs normal updates.
- Lookup latency: 0 cycles, combinational from pc_i.
- Shadow latency: 1 cycle from IF to ID.
- mispredict_o is combinational in the resolve cycle. The pipeline flushes IF/ID and loads redirect_pc_o at the same edge.
- A table write becomes visible to lookup on the cycle after the edge. If lookup and update hit the same index in the same cycle, lookup returns the old contents.
- stall_i and upd_valid_i together: training and statistics still happen once per upd_valid_i cycle. The pipeline deasserts upd_valid_i during a load-use stall, and the block does not dedupe.
- mispredict_o and stall_i together: the bubble wins.
- Aliasing: different PCs with the same index overwrite each other only when a taken branch misses.

## Test plan
- Reset mid-run: preload entry, pull start_i low between clock edges → pred_taken_o drops to 0 immediately; after release, lookup of the same PC → miss; stats read 0.
- Cold taken branch: upd pc=0x10, taken, target=0x40, shadow 0 → mispredict_o=1, redirect_pc_o=0x40, stat_mispred=1. Next cycle pc_i=0x10 → pred_taken_o=1, pred_target_o=0x40.
- Counter hysteresis (CNT_W=2): from weakly taken, resolve not-taken once → ctr=1, prediction 0. Resolve taken ×3 → ctr saturates at 3. One not-taken → still predicts taken.
- Correct prediction: pc=0x10 predicted 0x40, carried through shadow; upd taken to 0x40 → mispredict_o=0, stat_branches increments, stat_mispred unchanged.
- Predicted-taken but actually not-taken at pc=0x10 → mispredict_o=1, redirect_pc_o=0x14; next cycle shadow = 0 even with stall_i=0.
- Alias and saturation: ENTRIES=4, taken at 0x10 then taken at 0x20 (same index) → 0x10 now misses. With STAT_W=2, drive 5 branches → stat_branches_o holds 3.
